// File: rtl/ongoru_iz_surucu.sv
// Trace-replay driver for the ongorucu branch predictor. It replays a loaded branch trace,
// resolves each prediction EX_STAGE_LOC-1 cycles after fetch and keeps accuracy statistics.
`timescale 1ns/1ps
module ongoru_iz_surucu #(
   parameter int BRANCH_COUNT = 8,
   parameter int PC_LEN       = 32,
   parameter int INST_LEN     = 32,
   parameter int EX_STAGE_LOC = 3,
   parameter int PASS_COUNT   = 4,
   parameter int CNT_W        = 16,
   parameter int STALL_LIMIT  = 64,
   parameter int UPDATE_ALL   = 1,
   localparam int PTR_W       = (BRANCH_COUNT > 1) ? $clog2(BRANCH_COUNT) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_en,
   input  logic [PTR_W-1:0]    load_addr,
   input  logic [PC_LEN-1:0]   load_pc,
   input  logic [INST_LEN-1:0] load_inst,
   input  logic                load_tkn,
   input  logic [PC_LEN-1:0]   load_trg,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [PC_LEN-1:0]   getir_ps,
   output logic [INST_LEN-1:0] getir_buyruk,
   output logic                getir_gecerli,
   output logic [PC_LEN-1:0]   yurut_ps,
   output logic [INST_LEN-1:0] yurut_buyruk,
   output logic                yurut_dallan,
   output logic [PC_LEN-1:0]   yurut_dallan_ps,
   output logic                yurut_gecerli,
   input  logic                sonuc_dallan,
   input  logic [PC_LEN-1:0]   sonuc_dallan_ps,
   output logic [CNT_W-1:0]    br_count,
   output logic [CNT_W-1:0]    dir_mispred,
   output logic [CNT_W-1:0]    tgt_mispred,
   output logic [CNT_W-1:0]    resync_count,
   output logic [1:0]          state_dbg
);
   localparam int NST    = EX_STAGE_LOC - 1;
   localparam int PASS_W = $clog2(PASS_COUNT + 1);
   localparam int WD_W   = $clog2(STALL_LIMIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t state, state_nxt;

   logic [PC_LEN-1:0]   tr_pc   [BRANCH_COUNT];
   logic [INST_LEN-1:0] tr_inst [BRANCH_COUNT];
   logic                tr_tkn  [BRANCH_COUNT];
   logic [PC_LEN-1:0]   tr_trg  [BRANCH_COUNT];

   logic [PC_LEN-1:0] pc;
   logic [PTR_W-1:0]  fetch_ptr, res_ptr;
   logic [PASS_W-1:0] pass_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic [NST:1]      stg_v;
   logic              stg_tkn [1:NST];
   logic [PC_LEN-1:0] stg_trg [1:NST];

   logic fetch_hit, res_v, dir_miss, tgt_miss, mispred, res_last, final_res, idle, wd_fire;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BRANCH_COUNT - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (load_en && !busy) begin
         tr_pc[load_addr]   <= load_pc;
         tr_inst[load_addr] <= load_inst;
         tr_tkn[load_addr]  <= load_tkn;
         tr_trg[load_addr]  <= load_trg;
      end
   end

   assign fetch_hit = (state == S_RUN) && (pc == tr_pc[fetch_ptr]);
   assign res_v     = (state == S_RUN) && stg_v[NST];
   assign dir_miss  = res_v && (stg_tkn[NST] != tr_tkn[res_ptr]);
   assign tgt_miss  = res_v && (stg_tkn[NST] == tr_tkn[res_ptr]) && tr_tkn[res_ptr]
                      && (stg_trg[NST] != tr_trg[res_ptr]);
   assign mispred   = dir_miss || tgt_miss;
   assign res_last  = (res_ptr == PTR_W'(BRANCH_COUNT - 1));
   assign final_res = res_v && res_last && (pass_cnt == PASS_W'(PASS_COUNT - 1));
   assign idle      = (state == S_RUN) && !fetch_hit && (stg_v == '0);
   assign wd_fire   = idle && (wd_cnt == WD_W'(STALL_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
         S_RUN:          if (final_res) state_nxt = S_DRAIN;
         S_DRAIN:        state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // getir_gecerli / yurut_gecerli qualify their buses for exactly one cycle with no
   // backpressure: the predictor answers sonuc_* in the getir cycle and takes yurut_* when valid.
   always_comb begin
      busy            = (state == S_RUN) || (state == S_DRAIN);
      done            = (state == S_DONE);
      state_dbg       = state;
      getir_gecerli   = fetch_hit;
      getir_ps        = fetch_hit ? pc : '0;
      getir_buyruk    = fetch_hit ? tr_inst[fetch_ptr] : '0;
      yurut_gecerli   = res_v && ((UPDATE_ALL != 0) || mispred);
      yurut_ps        = res_v ? tr_pc[res_ptr] : '0;
      yurut_buyruk    = res_v ? tr_inst[res_ptr] : '0;
      yurut_dallan    = res_v && tr_tkn[res_ptr];
      yurut_dallan_ps = res_v ? tr_trg[res_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= '0;
         fetch_ptr    <= '0;
         res_ptr      <= '0;
         pass_cnt     <= '0;
         wd_cnt       <= '0;
         stg_v        <= '0;
         br_count     <= '0;
         dir_mispred  <= '0;
         tgt_mispred  <= '0;
         resync_count <= '0;
      end else if ((state == S_IDLE || state == S_DONE) && start) begin
         pc           <= tr_pc[0];
         fetch_ptr    <= '0;
         res_ptr      <= '0;
         pass_cnt     <= '0;
         wd_cnt       <= '0;
         stg_v        <= '0;
         br_count     <= '0;
         dir_mispred  <= '0;
         tgt_mispred  <= '0;
         resync_count <= '0;
      end else if (state == S_RUN) begin
         // A mispredict flushes everything, including a fetch made in the same cycle.
         if (mispred) begin
            stg_v <= '0;
         end else begin
            stg_v[1]   <= fetch_hit;
            stg_tkn[1] <= sonuc_dallan;
            stg_trg[1] <= sonuc_dallan_ps;
            for (int k = 2; k <= NST; k++) begin
               stg_v[k]   <= stg_v[k-1];
               stg_tkn[k] <= stg_tkn[k-1];
               stg_trg[k] <= stg_trg[k-1];
            end
         end

         if (mispred) begin
            pc        <= tr_tkn[res_ptr] ? tr_trg[res_ptr] : tr_pc[res_ptr] + PC_LEN'(4);
            fetch_ptr <= ptr_inc(res_ptr);
         end else if (wd_fire) begin
            pc <= tr_pc[fetch_ptr];
         end else if (fetch_hit) begin
            pc        <= sonuc_dallan ? sonuc_dallan_ps : pc + PC_LEN'(4);
            fetch_ptr <= ptr_inc(fetch_ptr);
         end else begin
            pc <= pc + PC_LEN'(4);
         end

         if (fetch_hit || wd_fire) wd_cnt <= '0;
         else if (idle)            wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_fire) resync_count <= sat_inc(resync_count);

         if (res_v) begin
            br_count <= sat_inc(br_count);
            if (dir_miss) dir_mispred <= sat_inc(dir_mispred);
            if (tgt_miss) tgt_mispred <= sat_inc(tgt_mispred);
            res_ptr <= ptr_inc(res_ptr);
            if (res_last) pass_cnt <= pass_cnt + PASS_W'(1);
         end
      end else if (state == S_DRAIN) begin
         stg_v <= '0;
      end
   end
endmodule

// File: tb/tb_ongoru_iz_surucu.sv
// Bench for ongoru_iz_surucu: a two-entry trace replayed against small predictor models,
// with a second instance (UPDATE_ALL=0) running in lockstep on the same inputs.
`timescale 1ns/1ps
module tb_ongoru_iz_surucu;
   localparam int M_ORACLE = 0;
   localparam int M_NT     = 1;
   localparam int M_BADTRG = 2;
   localparam int M_INV    = 3;

   typedef struct {
      int          mode;
      logic [31:0] e1_pc;
      logic [15:0] br, dir, tgt, rs;
      int          y_all, y_u0;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, load_en, load_tkn, start, sonuc_dallan;
   logic [0:0]  load_addr;
   logic [31:0] load_pc, load_inst, load_trg, sonuc_dallan_ps;

   logic        busy, done, getir_gecerli, yurut_dallan, yurut_gecerli;
   logic [31:0] getir_ps, getir_buyruk, yurut_ps, yurut_buyruk, yurut_dallan_ps;
   logic [15:0] br_count, dir_mispred, tgt_mispred, resync_count;
   logic [1:0]  state_dbg;

   logic        u_busy, u_done, u_getir_gecerli, u_yurut_dallan, u_yurut_gecerli;
   logic [31:0] u_getir_ps, u_getir_buyruk, u_yurut_ps, u_yurut_buyruk, u_yurut_dallan_ps;
   logic [15:0] u_br_count, u_dir_mispred, u_tgt_mispred, u_resync_count;
   logic [1:0]  u_state_dbg;

   ongoru_iz_surucu #(.BRANCH_COUNT(2), .PC_LEN(32), .INST_LEN(32), .EX_STAGE_LOC(3),
      .PASS_COUNT(1), .CNT_W(16), .STALL_LIMIT(16), .UPDATE_ALL(1)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_pc(load_pc),
      .load_inst(load_inst), .load_tkn(load_tkn), .load_trg(load_trg), .start(start),
      .busy(busy), .done(done), .getir_ps(getir_ps), .getir_buyruk(getir_buyruk),
      .getir_gecerli(getir_gecerli), .yurut_ps(yurut_ps), .yurut_buyruk(yurut_buyruk),
      .yurut_dallan(yurut_dallan), .yurut_dallan_ps(yurut_dallan_ps),
      .yurut_gecerli(yurut_gecerli), .sonuc_dallan(sonuc_dallan),
      .sonuc_dallan_ps(sonuc_dallan_ps), .br_count(br_count), .dir_mispred(dir_mispred),
      .tgt_mispred(tgt_mispred), .resync_count(resync_count), .state_dbg(state_dbg));

   ongoru_iz_surucu #(.BRANCH_COUNT(2), .PC_LEN(32), .INST_LEN(32), .EX_STAGE_LOC(3),
      .PASS_COUNT(1), .CNT_W(16), .STALL_LIMIT(16), .UPDATE_ALL(0)) dut_u0 (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_pc(load_pc),
      .load_inst(load_inst), .load_tkn(load_tkn), .load_trg(load_trg), .start(start),
      .busy(u_busy), .done(u_done), .getir_ps(u_getir_ps), .getir_buyruk(u_getir_buyruk),
      .getir_gecerli(u_getir_gecerli), .yurut_ps(u_yurut_ps), .yurut_buyruk(u_yurut_buyruk),
      .yurut_dallan(u_yurut_dallan), .yurut_dallan_ps(u_yurut_dallan_ps),
      .yurut_gecerli(u_yurut_gecerli), .sonuc_dallan(sonuc_dallan),
      .sonuc_dallan_ps(sonuc_dallan_ps), .br_count(u_br_count), .dir_mispred(u_dir_mispred),
      .tgt_mispred(u_tgt_mispred), .resync_count(u_resync_count), .state_dbg(u_state_dbg));

   int          n_chk = 0, n_pass = 0;
   int          mode = M_ORACLE;
   int          y_all, y_u0, ls_err;
   logic [31:0] bt_pc  [2];
   logic [31:0] bt_trg [2];
   logic        bt_tkn [2];
   logic        pi;

   // Predictor models, answering in the same cycle as the fetch request.
   always_comb begin
      pi              = (getir_ps == bt_pc[1]);
      sonuc_dallan    = 1'b0;
      sonuc_dallan_ps = '0;
      case (mode)
         M_ORACLE: begin sonuc_dallan = bt_tkn[pi]; sonuc_dallan_ps = bt_trg[pi]; end
         M_BADTRG: begin
            sonuc_dallan    = pi ? bt_tkn[pi] : 1'b1;
            sonuc_dallan_ps = pi ? bt_trg[pi] : 32'h300;
         end
         M_INV:    begin sonuc_dallan = !bt_tkn[pi]; sonuc_dallan_ps = bt_trg[pi]; end
         default:  ;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic load_entry(input logic a, input logic [31:0] p, input logic [31:0] inst,
                             input logic t, input logic [31:0] g);
      load_en = 1'b1; load_addr = a; load_pc = p; load_inst = inst; load_tkn = t; load_trg = g;
      tick();
      load_en = 1'b0;
   endtask

   task automatic setup(input int m, input logic [31:0] e1pc);
      mode = m;
      bt_pc[0] = 32'h100; bt_tkn[0] = 1'b1; bt_trg[0] = 32'h200;
      bt_pc[1] = e1pc;    bt_tkn[1] = 1'b0; bt_trg[1] = 32'h400;
      load_entry(1'b0, 32'h100, 32'hA0, 1'b1, 32'h200);
      load_entry(1'b1, e1pc,    32'hA1, 1'b0, 32'h400);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget && !done; c++) begin
         if (yurut_gecerli)   y_all++;
         if (u_yurut_gecerli) y_u0++;
         if ({getir_ps, getir_buyruk, getir_gecerli, yurut_ps, yurut_buyruk, yurut_dallan,
              yurut_dallan_ps, busy, done, br_count, dir_mispred, tgt_mispred, resync_count,
              state_dbg} !==
             {u_getir_ps, u_getir_buyruk, u_getir_gecerli, u_yurut_ps, u_yurut_buyruk,
              u_yurut_dallan, u_yurut_dallan_ps, u_busy, u_done, u_br_count, u_dir_mispred,
              u_tgt_mispred, u_resync_count, u_state_dbg}) ls_err++;
         tick();
      end
      chk("run_done", {31'd0, done}, 32'd1);
   endtask

   task automatic run_full();
      y_all = 0; y_u0 = 0; ls_err = 0;
      pulse_start();
      wait_done(100);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{mode: M_ORACLE, e1_pc: 32'h200,  br: 2, dir: 0, tgt: 0, rs: 0, y_all: 2, y_u0: 0};
      vecs[1] = '{mode: M_NT,     e1_pc: 32'h200,  br: 2, dir: 1, tgt: 0, rs: 0, y_all: 2, y_u0: 1};
      vecs[2] = '{mode: M_BADTRG, e1_pc: 32'h200,  br: 2, dir: 0, tgt: 1, rs: 0, y_all: 2, y_u0: 1};
      vecs[3] = '{mode: M_INV,    e1_pc: 32'h200,  br: 2, dir: 2, tgt: 0, rs: 0, y_all: 2, y_u0: 2};
      vecs[4] = '{mode: M_ORACLE, e1_pc: 32'h1000, br: 2, dir: 0, tgt: 0, rs: 1, y_all: 2, y_u0: 0};

      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_pc = '0; load_inst = '0;
      load_tkn = 1'b0; load_trg = '0; start = 1'b0;
      y_all = 0; y_u0 = 0; ls_err = 0;
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_getir_v", {31'd0, getir_gecerli}, 0);
      chk("rst_getir_ps", getir_ps, 0);
      chk("rst_yurut_v", {31'd0, yurut_gecerli}, 0);
      chk("rst_br", br_count, 0);
      chk("rst_state", {30'd0, state_dbg}, 0);

      // start while reset is held must not launch a run
      start = 1'b1; tick(); start = 1'b0; tick();
      chk("start_in_rst_busy", {31'd0, busy}, 0);
      rst = 1'b0; tick();
      chk("after_rst_busy", {31'd0, busy}, 0);

      for (int i = 0; i < 5; i++) begin
         setup(vecs[i].mode, vecs[i].e1_pc);
         run_full();
         chk($sformatf("v%0d_br", i), br_count, vecs[i].br);
         chk($sformatf("v%0d_dir", i), dir_mispred, vecs[i].dir);
         chk($sformatf("v%0d_tgt", i), tgt_mispred, vecs[i].tgt);
         chk($sformatf("v%0d_resync", i), resync_count, vecs[i].rs);
         chk($sformatf("v%0d_yurut_all", i), y_all, vecs[i].y_all);
         chk($sformatf("v%0d_yurut_u0", i), y_u0, vecs[i].y_u0);
         chk($sformatf("v%0d_lockstep", i), ls_err, 0);
      end
      repeat (3) tick();
      chk("done_held", {31'd0, done}, 1);

      // oracle: fetch at R0 resolves at R2; start while busy is ignored
      setup(M_ORACLE, 32'h200);
      pulse_start();
      chk("a_r0_getir_v", {31'd0, getir_gecerli}, 1);
      chk("a_r0_getir_ps", getir_ps, 32'h100);
      chk("a_r0_getir_inst", getir_buyruk, 32'hA0);
      start = 1'b1; tick(); start = 1'b0;
      chk("a_r1_getir_ps", getir_ps, 32'h200);
      chk("a_r1_yurut_v", {31'd0, yurut_gecerli}, 0);
      tick();
      chk("a_r2_yurut_v", {31'd0, yurut_gecerli}, 1);
      chk("a_r2_yurut_ps", yurut_ps, 32'h100);
      chk("a_r2_yurut_inst", yurut_buyruk, 32'hA0);
      chk("a_r2_yurut_dallan", {31'd0, yurut_dallan}, 1);
      chk("a_r2_yurut_trg", yurut_dallan_ps, 32'h200);
      chk("a_r2_u0_yurut_v", {31'd0, u_yurut_gecerli}, 0);
      wait_done(100);
      chk("a_br", br_count, 2);

      // always-not-taken: flush at R2, redirect to 0x200 at R3
      setup(M_NT, 32'h200);
      pulse_start();
      tick(); tick();
      chk("b_r2_u0_yurut_v", {31'd0, u_yurut_gecerli}, 1);
      chk("b_r2_yurut_dallan", {31'd0, yurut_dallan}, 1);
      tick();
      chk("b_r3_getir_v", {31'd0, getir_gecerli}, 1);
      chk("b_r3_getir_ps", getir_ps, 32'h200);
      chk("b_r3_dir", dir_mispred, 1);
      wait_done(100);

      // wrong target 0x300: no fetch on that path, redirect to 0x200
      setup(M_BADTRG, 32'h200);
      pulse_start();
      tick();
      chk("c_r1_getir_v", {31'd0, getir_gecerli}, 0);
      tick();
      chk("c_r2_u0_yurut_v", {31'd0, u_yurut_gecerli}, 1);
      tick();
      chk("c_r3_getir_ps", getir_ps, 32'h200);
      chk("c_r3_tgt", tgt_mispred, 1);
      wait_done(100);

      // unreachable entry: idle R3..R18, resync lands at R19
      setup(M_ORACLE, 32'h1000);
      pulse_start();
      repeat (18) tick();
      chk("d_r18_resync", resync_count, 0);
      chk("d_r18_getir_v", {31'd0, getir_gecerli}, 0);
      tick();
      chk("d_r19_resync", resync_count, 1);
      chk("d_r19_getir_v", {31'd0, getir_gecerli}, 1);
      chk("d_r19_getir_ps", getir_ps, 32'h1000);
      wait_done(100);

      // reset mid-run, then rerun with the retained trace
      setup(M_ORACLE, 32'h200);
      pulse_start();
      tick(); tick();
      chk("e_busy_mid", {31'd0, busy}, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("e_rst_busy", {31'd0, busy}, 0);
      chk("e_rst_done", {31'd0, done}, 0);
      chk("e_rst_br", br_count, 0);
      chk("e_rst_yurut_v", {31'd0, yurut_gecerli}, 0);
      chk("e_rst_state", {30'd0, state_dbg}, 0);
      run_full();
      chk("e_br", br_count, 2);
      chk("e_dir", dir_mispred, 0);
      chk("e_tgt", tgt_mispred, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ongoru_iz_surucu.md
Name: ongoru_iz_surucu

Overview:
Synthesizable, parametrised trace-replay driver for the branch predictor (`ongorucu` port set). It holds a loadable branch trace and emulates a fetch PC plus an EX_STAGE_LOC-deep pipeline. It drives the predictor's fetch and execute ports, resolves each prediction, flushes and redirects on mispredict, and keeps saturating accuracy counters over PASS_COUNT passes. It is the generalised hardware successor to the simulation-only predictor harness: configurable depth, trace length, pass count and update mode, with a resync watchdog and separate direction/target statistics.

Parameters:
BRANCH_COUNT, 8, trace entries (>=2; ptr width $clog2)
PC_LEN, 32, PC/target width
INST_LEN, 32, instruction width
EX_STAGE_LOC, 3, resolve stage index (>=2); branch resolves EX_STAGE_LOC-1 cycles after fetch
PASS_COUNT, 4, full trace passes per run (>=1)
CNT_W, 16, statistics counter width
STALL_LIMIT, 64, idle-fetch cycles before resync
UPDATE_ALL, 1, 1: yurut_gecerli on every resolution; 0: only on mispredict

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
load_en  in  1  write trace entry (ignored while busy)
load_addr  in  $clog2(BRANCH_COUNT)  entry index
load_pc / load_inst / load_tkn / load_trg  in  PC_LEN / INST_LEN / 1 / PC_LEN  entry fields
start  in  1  one-cycle pulse; begins run from IDLE or DONE
busy  out  1  RUN/DRAIN active
done  out  1  run finished; held until start or rst
getir_ps / getir_buyruk / getir_gecerli  out  PC_LEN / INST_LEN / 1  fetch-side predictor request
yurut_ps / yurut_buyruk / yurut_dallan / yurut_dallan_ps / yurut_gecerli  out  PC_LEN / INST_LEN / 1 / PC_LEN / 1  execute-side update
sonuc_dallan / sonuc_dallan_ps  in  1 / PC_LEN  predictor result (same cycle as getir)
br_count, dir_mispred, tgt_mispred, resync_count  out  CNT_W each  statistics

Behaviour:
- Reset: state IDLE. All outputs 0. Pipeline valids 0, pointers 0, pass counter 0, fetch PC 0. Trace memory is not cleared. Reset mid-run aborts immediately.
- FSM:
  - IDLE --start--> RUN: clear counters; fetch_ptr = res_ptr = 0; pc = trace[0].pc.
  - RUN --final resolution--> DRAIN (one cycle; clear pipeline) --> DONE.
  - DONE --start--> RUN.
  - start while busy: ignored.
- Fetch (RUN only):
  - If pc == trace[fetch_ptr].pc: getir_gecerli = 1, getir_* = entry. Stage 1 captures {valid, fetch_ptr, sonuc_dallan, sonuc_dallan_ps}. fetch_ptr advances, wrapping at BRANCH_COUNT-1 -> 0.
  - Next pc = sonuc_dallan ? sonuc_dallan_ps : pc+4.
  - Otherwise getir_gecerli = 0, pc += 4 (modulo 2^PC_LEN).
- Pipeline:
  - Stages 1..EX_STAGE_LOC-1 shift each cycle; an empty slot shifts in when nothing is fetched.
  - Resolve occurs at stage EX_STAGE_LOC-1 when valid, using entry e = trace[res_ptr]:
    - dir_miss = pred_tkn != e.tkn.
    - tgt_miss = !dir_miss && e.tkn && pred_trg != e.trg.
    - yurut_* = e fields. yurut_gecerli = valid && (UPDATE_ALL || dir_miss || tgt_miss), same cycle.
    - br_count++. dir_mispred++ on dir_miss; tgt_mispred++ on tgt_miss. Counters saturate at all-ones.
    - res_ptr advances with wrap. On wrap, pass counter increments; after the PASS_COUNT-th wrap the FSM goes to DRAIN.
  - Mispredict:
    - Flush all stages next edge; a same-cycle fetch is discarded (flush wins).
    - pc <= e.tkn ? e.trg : e.pc+4.
    - fetch_ptr <= res_ptr+1 (wrapped).
- Watchdog: counts cycles in RUN with no fetch hit and an empty pipeline. On reaching STALL_LIMIT: pc <= trace[fetch_ptr].pc, resync_count++, watchdog clears. Any fetch hit also clears it.
- Final resolution: counters update normally; wrong-path entries fetched afterwards are discarded without counting.

Test Plan:
- Reset -> all outputs 0, busy 0, done 0. Start with rst high -> ignored.
- BRANCH_COUNT=2, PASS_COUNT=1, EX_STAGE_LOC=3, trace {0x100 taken->0x200}, {0x200 not-taken}, oracle predictor -> br_count=2, dir_mispred=0, tgt_mispred=0, done=1. Branch fetched at cycle t resolves at t+2.
- Same trace, always-not-taken predictor -> entry0 dir_mispred=1; pipeline flushed; pc=0x200 the cycle after resolve; final dir_mispred=1.
- Predictor taken to 0x300 for entry0 -> tgt_mispred=1; 0x300-path fetches discarded; pc redirected to 0x200.
- Entry1 pc=0x1000 unreachable, STALL_LIMIT=16 -> resync_count=1 after 16 idle cycles, then 0x1000 fetched.
- UPDATE_ALL=0 with oracle predictor -> yurut_gecerli never high.
- rst mid-run, then restart -> busy=0 and counters 0 after rst; rerun yields the same counts as the first run.
